// File: rtl/ball_controller.sv
// Pong game logic: advances the ball once per video frame, bounces it off walls and pads,
// and sequences serve, point hold, scoring and game over.
module ball_controller #(
    parameter int HOR_PIXELS  = 1024,
    parameter int VER_PIXELS  = 768,
    parameter int BALL_SIZE   = 15,
    parameter int BALL_SPEED  = 4,
    parameter int PAD_HEIGHT  = 145,
    parameter int PAD_WIDTH   = 15,
    parameter int X_PAD_LEFT  = 30,
    parameter int X_PAD_RIGHT = 979,
    parameter int SCORE_HOLD  = 60,
    parameter int MAX_SCORE   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       serve,
    input  logic [9:0] y_pad_left,
    input  logic [9:0] y_pad_right,
    output logic [9:0] x_ball,
    output logic [9:0] y_ball,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       point_left,
    output logic       point_right,
    output logic       game_over
);

    localparam logic [9:0]  X_C    = 10'((HOR_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_C    = 10'((VER_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_MAX  = 10'(VER_PIXELS - 1 - BALL_SIZE);
    localparam logic [9:0]  XL_LIM = 10'(X_PAD_LEFT + PAD_WIDTH + 1);
    localparam logic [9:0]  XR_LIM = 10'(X_PAD_RIGHT - 1 - BALL_SIZE);
    localparam logic [10:0] SPEED_W = 11'(BALL_SPEED);
    localparam logic [10:0] SIZE_W  = 11'(BALL_SIZE);
    localparam logic [10:0] PADH_W  = 11'(PAD_HEIGHT);
    localparam int          HOLD_W  = $clog2(SCORE_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCORE_HOLD - 1);
    localparam logic [3:0]  SCORE_MAX = 4'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, PLAY, SCORED, GAME_OVER} state_t;

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              dir_x_q, dir_x_d;
    logic              dir_y_q, dir_y_d;
    logic [3:0]        score_left_q, score_left_d, score_right_q, score_right_d;
    logic              point_left_q, point_left_d, point_right_q, point_right_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              vblnk_q;

    logic              tick;
    logic [10:0]       x_w, y_w, pad_l_w, pad_r_w;
    logic              overlap_l, overlap_r;

    assign tick      = vblnk & ~vblnk_q;
    assign x_w       = {1'b0, x_q};
    assign y_w       = {1'b0, y_q};
    assign pad_l_w   = {1'b0, y_pad_left};
    assign pad_r_w   = {1'b0, y_pad_right};
    assign overlap_l = (y_w + SIZE_W >= pad_l_w) && (y_w <= pad_l_w + PADH_W);
    assign overlap_r = (y_w + SIZE_W >= pad_r_w) && (y_w <= pad_r_w + PADH_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            x_q           <= X_C;
            y_q           <= Y_C;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            point_left_q  <= 1'b0;
            point_right_q <= 1'b0;
            hold_q        <= '0;
            vblnk_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            point_left_q  <= point_left_d;
            point_right_q <= point_right_d;
            hold_q        <= hold_d;
            vblnk_q       <= vblnk;
        end
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        point_left_d  = 1'b0;
        point_right_d = 1'b0;
        hold_d        = hold_q;
        case (state_q)
            IDLE: begin
                x_d = X_C;
                y_d = Y_C;
                if (serve) state_d = PLAY;
            end
            PLAY: if (tick) begin
                if (dir_y_q && (y_w + SPEED_W >= {1'b0, Y_MAX})) begin
                    y_d     = Y_MAX;
                    dir_y_d = 1'b0;
                end else if (!dir_y_q && (y_w <= SPEED_W)) begin
                    y_d     = 10'd0;
                    dir_y_d = 1'b1;
                end else if (dir_y_q) begin
                    y_d = 10'(y_w + SPEED_W);
                end else begin
                    y_d = 10'(y_w - SPEED_W);
                end
                // A miss leaves dir_x pointing at the conceding side, which is the next serve direction.
                if (dir_x_q) begin
                    if (x_w + SPEED_W >= {1'b0, XR_LIM}) begin
                        x_d = XR_LIM;
                        if (overlap_r) begin
                            dir_x_d = 1'b0;
                        end else begin
                            point_left_d = 1'b1;
                            score_left_d = (score_left_q == SCORE_MAX) ? score_left_q
                                                                       : score_left_q + 4'd1;
                            hold_d       = '0;
                            state_d      = SCORED;
                        end
                    end else begin
                        x_d = 10'(x_w + SPEED_W);
                    end
                end else begin
                    if (x_w <= {1'b0, XL_LIM} + SPEED_W) begin
                        x_d = XL_LIM;
                        if (overlap_l) begin
                            dir_x_d = 1'b1;
                        end else begin
                            point_right_d = 1'b1;
                            score_right_d = (score_right_q == SCORE_MAX) ? score_right_q
                                                                         : score_right_q + 4'd1;
                            hold_d        = '0;
                            state_d       = SCORED;
                        end
                    end else begin
                        x_d = 10'(x_w - SPEED_W);
                    end
                end
            end
            SCORED: if (tick) begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (score_left_q == SCORE_MAX || score_right_q == SCORE_MAX) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d = IDLE;
                        x_d     = X_C;
                        y_d     = Y_C;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAME_OVER: if (serve) begin
                score_left_d  = 4'd0;
                score_right_d = 4'd0;
                x_d           = X_C;
                y_d           = Y_C;
                dir_x_d       = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        game_over = (state_q == GAME_OVER);
    end

    assign x_ball      = x_q;
    assign y_ball      = y_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign point_left  = point_left_q;
    assign point_right = point_right_q;

endmodule

// File: tb/tb_ball_controller.sv
// Self-checking bench for ball_controller: directed game scenarios plus randomized frames,
// compared every clock against a frame-level model of ball motion and scoring.
module tb_ball_controller;

    logic       clk = 1'b0;
    logic       rst, vblnk, serve;
    logic [9:0] yPadLeft, yPadRight;
    logic [9:0] xBall, yBall;
    logic [3:0] scoreLeft, scoreRight;
    logic       pointLeft, pointRight, gameOver;

    ball_controller dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .serve      (serve),
        .y_pad_left (yPadLeft),
        .y_pad_right(yPadRight),
        .x_ball     (xBall),
        .y_ball     (yBall),
        .score_left (scoreLeft),
        .score_right(scoreRight),
        .point_left (pointLeft),
        .point_right(pointRight),
        .game_over  (gameOver)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pointLeftSeen = 0;

    // Model: ball position/velocity in plain integers, game phase as a small mode number.
    localparam int M_WAIT = 0, M_RUN = 1, M_HELD = 2, M_OVER = 3;
    int mX, mY, mVx, mVy, mSL, mSR, mMode, mHeld;
    bit mPL, mPR, mPrevVb;

    task automatic modelReset();
        mX = 504; mY = 376; mVx = 4; mVy = 4;
        mSL = 0; mSR = 0; mMode = M_WAIT; mHeld = 0;
        mPL = 0; mPR = 0; mPrevVb = 0;
    endtask

    task automatic modelStep(input bit vb, input bit sv, input bit rs, input int pl, input int pr);
        bit tick, ovL, ovR;
        int nx, ny;
        if (rs) begin
            modelReset();
            return;
        end
        tick = vb && !mPrevVb;
        mPrevVb = vb;
        mPL = 0;
        mPR = 0;
        case (mMode)
            M_WAIT: if (sv) mMode = M_RUN;
            M_RUN: if (tick) begin
                ovL = (mY + 15 >= pl) && (mY <= pl + 145);
                ovR = (mY + 15 >= pr) && (mY <= pr + 145);
                ny = mY + mVy;
                if (ny >= 752) begin ny = 752; mVy = -4; end
                else if (ny <= 0) begin ny = 0; mVy = 4; end
                nx = mX + mVx;
                if (nx >= 963) begin
                    nx = 963;
                    if (ovR) mVx = -4;
                    else begin
                        mSL = (mSL >= 9) ? 9 : mSL + 1;
                        mPL = 1; mMode = M_HELD; mHeld = 0;
                    end
                end else if (nx <= 46) begin
                    nx = 46;
                    if (ovL) mVx = 4;
                    else begin
                        mSR = (mSR >= 9) ? 9 : mSR + 1;
                        mPR = 1; mMode = M_HELD; mHeld = 0;
                    end
                end
                mX = nx;
                mY = ny;
            end
            M_HELD: if (tick) begin
                mHeld++;
                if (mHeld == 60) begin
                    if (mSL == 9 || mSR == 9) mMode = M_OVER;
                    else begin
                        mVx = (mX == 963) ? 4 : -4;
                        mX = 504; mY = 376; mMode = M_WAIT;
                    end
                end
            end
            default: if (sv) begin
                mSL = 0; mSR = 0; mX = 504; mY = 376; mVx = 4; mMode = M_WAIT;
            end
        endcase
    endtask

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic vb, input logic sv, input logic rs,
                                 input logic [9:0] pl, input logic [9:0] pr);
        @(negedge clk);
        vblnk = vb; serve = sv; rst = rs; yPadLeft = pl; yPadRight = pr;
        @(posedge clk);
        modelStep(vb, sv, rs, int'(pl), int'(pr));
        #1;
        checkOutput("x_ball", int'(xBall), mX);
        checkOutput("y_ball", int'(yBall), mY);
        checkOutput("score_left", int'(scoreLeft), mSL);
        checkOutput("score_right", int'(scoreRight), mSR);
        checkOutput("point_left", int'(pointLeft), int'(mPL));
        checkOutput("point_right", int'(pointRight), int'(mPR));
        checkOutput("game_over", int'(gameOver), int'(mMode == M_OVER));
        if (pointLeft) pointLeftSeen++;
    endtask

    task automatic runFrames(input int n, input logic [9:0] pl, input logic [9:0] pr);
        for (int f = 0; f < n; f++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, pl, pr);
            applyStimulus(1'b0, 1'b0, 1'b0, pl, pr);
            applyStimulus(1'b0, 1'b0, 1'b0, pl, pr);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_x"}, int'(xBall), 504);
        checkOutput({tag, "_y"}, int'(yBall), 376);
        checkOutput({tag, "_sl"}, int'(scoreLeft), 0);
        checkOutput({tag, "_sr"}, int'(scoreRight), 0);
        checkOutput({tag, "_pl"}, int'(pointLeft), 0);
        checkOutput({tag, "_pr"}, int'(pointRight), 0);
        checkOutput({tag, "_go"}, int'(gameOver), 0);
    endtask

    function automatic logic [9:0] pickPad();
        int p;
        if ($urandom_range(0, 3) != 0) begin
            p = mY - int'($urandom_range(0, 140));
            if (p < 0) p = 0;
        end else begin
            p = int'($urandom_range(0, 1023));
        end
        return 10'(p);
    endfunction

    initial begin
        rst = 1'b1; vblnk = 1'b0; serve = 1'b0; yPadLeft = '0; yPadRight = '0;
        modelReset();

        applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
        checkResetValues("reset");
        runFrames(3, 10'd0, 10'd600);
        checkOutput("idle_x", int'(xBall), 504);
        checkOutput("idle_y", int'(yBall), 376);

        // Bounce off the right pad.
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd600);
        runFrames(1, 10'd0, 10'd600);
        checkOutput("t1_x", int'(xBall), 508);
        checkOutput("t1_y", int'(yBall), 380);
        runFrames(93, 10'd0, 10'd600);
        checkOutput("t94_y", int'(yBall), 752);
        runFrames(1, 10'd0, 10'd600);
        checkOutput("t95_y", int'(yBall), 748);
        runFrames(20, 10'd0, 10'd600);
        checkOutput("t115_x", int'(xBall), 963);
        checkOutput("t115_y", int'(yBall), 668);
        runFrames(1, 10'd0, 10'd600);
        checkOutput("t116_x", int'(xBall), 959);

        // Miss on the right: point to the left player, then hold.
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'd312);
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd312);
        runFrames(114, 10'd0, 10'd312);
        pointLeftSeen = 0;
        runFrames(1, 10'd0, 10'd312);
        checkOutput("miss_x", int'(xBall), 963);
        checkOutput("miss_sl", int'(scoreLeft), 1);
        checkOutput("miss_pulse_cycles", pointLeftSeen, 1);
        runFrames(59, 10'd0, 10'd312);
        checkOutput("hold_x", int'(xBall), 963);
        runFrames(1, 10'd0, 10'd312);
        checkOutput("after_hold_x", int'(xBall), 504);
        checkOutput("after_hold_y", int'(yBall), 376);
        runFrames(2, 10'd0, 10'd312);
        checkOutput("idle_again_x", int'(xBall), 504);

        // Eight more left points reach game over.
        for (int p = 0; p < 8; p++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd1000);
            runFrames(200, 10'd0, 10'd1000);
        end
        checkOutput("over_flag", int'(gameOver), 1);
        checkOutput("over_sl", int'(scoreLeft), 9);
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd1000);
        checkOutput("restart_sl", int'(scoreLeft), 0);
        checkOutput("restart_go", int'(gameOver), 0);
        checkOutput("restart_x", int'(xBall), 504);

        // Reset mid-play and mid-hold.
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd1000);
        runFrames(20, 10'd0, 10'd1000);
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'd1000);
        checkResetValues("rst_play");
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd0, 10'd1000);
        runFrames(130, 10'd0, 10'd1000);
        checkOutput("held_sl", int'(scoreLeft), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 10'd1000);
        checkResetValues("rst_held");

        // Randomized frames, pads, serves and rare resets.
        for (int f = 0; f < 3000; f++) begin
            int hi, lo;
            logic [9:0] pl, pr;
            hi = int'($urandom_range(1, 3));
            lo = int'($urandom_range(1, 3));
            pl = pickPad();
            pr = pickPad();
            for (int c = 0; c < hi + lo; c++) begin
                applyStimulus(c < hi, $urandom_range(0, 15) == 0,
                              $urandom_range(0, 1999) == 0, pl, pr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_controller.md
Name: ball_controller

Overview:
- Game-logic producer of ball position and score; feeds the ball/pad renderer its ball coordinates once per frame.
- Advances the ball one step per video frame and bounces it off the top/bottom walls and both pads.
- Detects misses, keeps the score for both players, and sequences serve, point hold and game over.

Parameters:
- HOR_PIXELS, 1024: visible width.
- VER_PIXELS, 768: visible height.
- BALL_SIZE, 15: ball box spans x..x+BALL_SIZE and y..y+BALL_SIZE, inclusive.
- BALL_SPEED, 4: pixels per frame on each axis.
- PAD_HEIGHT, 145: pad spans y..y+PAD_HEIGHT, inclusive.
- PAD_WIDTH, 15: pad spans x..x+PAD_WIDTH, inclusive.
- X_PAD_LEFT, 30: left pad x.
- X_PAD_RIGHT, 979: right pad x.
- SCORE_HOLD, 60: frames the ball stays frozen after a point.
- MAX_SCORE, 9: score that ends the game.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- vblnk  in  1  vertical blank from VGA timing; its rising edge is the frame tick
- serve  in  1  level; starts play from IDLE, restarts from GAME_OVER
- y_pad_left  in  10  left pad top y
- y_pad_right  in  10  right pad top y
- x_ball  out  10  ball box left x
- y_ball  out  10  ball box top y
- score_left  out  4  left player score
- score_right  out  4  right player score
- point_left  out  1  one-cycle pulse when left player scores
- point_right  out  1  one-cycle pulse when right player scores
- game_over  out  1  high while in GAME_OVER

Behaviour:
- Derived constants:
  - X_C=(HOR_PIXELS-BALL_SIZE)/2=504, Y_C=(VER_PIXELS-BALL_SIZE)/2=376.
  - Y_MAX=VER_PIXELS-1-BALL_SIZE=752.
  - XL_LIM=X_PAD_LEFT+PAD_WIDTH+1=46, XR_LIM=X_PAD_RIGHT-1-BALL_SIZE=963.
- Arithmetic: comparisons in 11 bits, no wrap; the ball never leaves 0..XR_LIM / 0..Y_MAX.
- tick = vblnk & ~vblnk_q, with vblnk_q registered. All position, state and score updates occur on the clock edge where tick=1; outputs change one clock after tick is high.
- Reset:
  - x_ball=504, y_ball=376, scores=0, pulses=0, game_over=0.
  - dir_x=right, dir_y=down, state=IDLE, hold counter=0.
- IDLE: ball held at centre. serve=1 on any clock -> PLAY next clock (no tick needed).
- PLAY, per tick, axes evaluated independently in the same tick:
  - Y axis:
    - If dir_y=down and y+SPEED>=Y_MAX: y=Y_MAX, dir_y=up.
    - Else if dir_y=up and y<=SPEED: y=0, dir_y=down.
    - Else y±=SPEED.
  - Overlap test uses current y: overlapL = (y+BALL_SIZE>=y_pad_left) && (y<=y_pad_left+PAD_HEIGHT); overlapR is the same against y_pad_right. Pad inputs are sampled at the tick.
  - X axis, moving right:
    - If x+SPEED>=XR_LIM and overlapR: x=XR_LIM, dir_x=left.
    - If x+SPEED>=XR_LIM and not overlapR: x=XR_LIM, point_left pulse, score_left+1, next state SCORED.
    - Otherwise x+=SPEED.
  - X axis, moving left: mirror of the above, using XL_LIM and overlapL; a miss gives point_right and score_right+1.
- SCORED:
  - Ball frozen.
  - Counts SCORE_HOLD ticks. On the last one, if either score==MAX_SCORE -> GAME_OVER.
  - Otherwise -> IDLE with x=504, y=376, dir_x pointing toward the player who conceded; dir_y unchanged.
- GAME_OVER:
  - game_over=1, ball frozen.
  - serve=1 -> scores=0, ball centred, dir_x=right, IDLE.
- Scores never exceed MAX_SCORE. Pulses are exactly one clock wide.
- rst has priority over everything and takes effect mid-frame or mid-hold; it clears tick history (vblnk_q=0).
- serve is ignored in PLAY and SCORED.

Test Plan:
- Reset, then 3 vblnk rising edges with serve=0 -> x=504, y=376, scores 0, all pulses 0.
- serve pulse, then 1 tick -> x=508, y=380, updated 1 clk after tick.
- Continue to tick 94 -> y=752 with dir up. Tick 95 -> y=748.
- y_pad_right=600 held -> tick 115 gives x=963 (bounce), y=668. Tick 116 gives x=959.
- y_pad_right=312 -> tick 115:
  - x=963, point_left high exactly 1 clk, score_left=1.
  - Ball frozen for 60 ticks, then 504/376, back in IDLE.
- Drive 9 left points -> game_over=1 and score_left=9. Then serve -> scores 0, IDLE.
- Assert rst mid-PLAY and mid-SCORED -> all outputs return to reset values next clock.
